lcd_timing_controller: RTL and testbench

Master display sequencer for the graphics block. It generates the slot/column/row counters that the background processing circuit assumes: four per-background slots per dot, 308 dots per line and 228 lines per frame. It produces the row-step and new-frame strobes for the rotation/scaling units, the bitmap page-flip `frame` bit, and the blank flags. It also owns the DISPSTAT/VCOUNT register state and raises blanking/VCOUNT interrupts and DMA triggers.

---
 rtl/lcd_timing_controller.sv | 153 +++++++++++++++
 tb/tb_lcd_timing_controller.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_timing_controller.sv
// Display timing sequencer: cascaded slot/column/row counters, blank flags, DISPSTAT/VCOUNT
// state, and the line/frame/blank event pulses that drive IRQs and DMA triggers.
module lcd_timing_controller #(
  parameter int SLOTS     = 4,
  parameter int H_TOTAL   = 308,
  parameter int H_VISIBLE = 240,
  parameter int V_TOTAL   = 228,
  parameter int V_VISIBLE = 160
) (
  input  logic        clock,
  input  logic        rst_b,
  input  logic        enable,
  input  logic        dispstat_wr,
  input  logic [15:0] dispstat_wdata,
  output logic [15:0] dispstat,
  output logic [7:0]  vcount,
  output logic [8:0]  col,
  output logic [1:0]  slot,
  output logic        hblank,
  output logic        vblank,
  output logic        vcount_match,
  output logic        start_row,
  output logic        new_frame,
  output logic        frame,
  output logic        irq_vblank,
  output logic        irq_hblank,
  output logic        irq_vcount,
  output logic        dma_hblank_req,
  output logic        dma_vblank_req
);

  localparam logic [1:0] SLOT_LAST    = 2'(SLOTS - 1);
  localparam logic [8:0] COL_LAST     = 9'(H_TOTAL - 1);
  localparam logic [8:0] COL_HVIS     = 9'(H_VISIBLE);
  localparam logic [7:0] ROW_LAST     = 8'(V_TOTAL - 1);
  localparam logic [7:0] ROW_VVIS     = 8'(V_VISIBLE);
  localparam logic [7:0] ROW_VBL_LAST = 8'(V_TOTAL - 2);

  logic [1:0] slot_q, slot_d, slot_nx;
  logic [8:0] col_q, col_d, col_nx;
  logic [7:0] vcount_q, vcount_d, vcount_nx;
  logic       frame_q, frame_d;
  logic [7:0] lyc_q, lyc_d;
  logic       vcnt_ie_q, vcnt_ie_d;
  logic       hblank_ie_q, hblank_ie_d;
  logic       vblank_ie_q, vblank_ie_d;
  logic       start_row_q, start_row_d;
  logic       hbl_ent_q, hbl_ent_d;
  logic       hbl_pulse, vbl_pulse;
  logic       unused_wdata;

  assign unused_wdata = ^{dispstat_wdata[7:6], dispstat_wdata[2:0]};

  always_comb begin
    slot_nx   = slot_q;
    col_nx    = col_q;
    vcount_nx = vcount_q;
    if (slot_q == SLOT_LAST) begin
      slot_nx = 2'd0;
      if (col_q == COL_LAST) begin
        col_nx    = 9'd0;
        vcount_nx = (vcount_q == ROW_LAST) ? 8'd0 : vcount_q + 8'd1;
      end else begin
        col_nx = col_q + 9'd1;
      end
    end else begin
      slot_nx = slot_q + 2'd1;
    end
  end

  // Event registers capture "next position is an event" and hold through stalls,
  // so a deferred event is presented on the next enabled cycle.
  always_comb begin
    slot_d      = slot_q;
    col_d       = col_q;
    vcount_d    = vcount_q;
    frame_d     = frame_q;
    start_row_d = start_row_q;
    hbl_ent_d   = hbl_ent_q;
    if (enable) begin
      slot_d      = slot_nx;
      col_d       = col_nx;
      vcount_d    = vcount_nx;
      start_row_d = (slot_nx == 2'd0) && (col_nx == 9'd0);
      hbl_ent_d   = (slot_nx == 2'd0) && (col_nx == COL_HVIS);
      if ((slot_nx == 2'd0) && (col_nx == 9'd0) && (vcount_nx == 8'd0)) begin
        frame_d = ~frame_q;
      end
    end
  end

  always_comb begin
    lyc_d       = lyc_q;
    vcnt_ie_d   = vcnt_ie_q;
    hblank_ie_d = hblank_ie_q;
    vblank_ie_d = vblank_ie_q;
    if (dispstat_wr) begin
      lyc_d       = dispstat_wdata[15:8];
      vcnt_ie_d   = dispstat_wdata[5];
      hblank_ie_d = dispstat_wdata[4];
      vblank_ie_d = dispstat_wdata[3];
    end
  end

  always_ff @(posedge clock or negedge rst_b) begin
    if (!rst_b) begin
      slot_q      <= 2'd0;
      col_q       <= 9'd0;
      vcount_q    <= 8'd0;
      frame_q     <= 1'b0;
      lyc_q       <= 8'd0;
      vcnt_ie_q   <= 1'b0;
      hblank_ie_q <= 1'b0;
      vblank_ie_q <= 1'b0;
      start_row_q <= 1'b0;
      hbl_ent_q   <= 1'b0;
    end else begin
      slot_q      <= slot_d;
      col_q       <= col_d;
      vcount_q    <= vcount_d;
      frame_q     <= frame_d;
      lyc_q       <= lyc_d;
      vcnt_ie_q   <= vcnt_ie_d;
      hblank_ie_q <= hblank_ie_d;
      vblank_ie_q <= vblank_ie_d;
      start_row_q <= start_row_d;
      hbl_ent_q   <= hbl_ent_d;
    end
  end

  assign slot         = slot_q;
  assign col          = col_q;
  assign vcount       = vcount_q;
  assign frame        = frame_q;
  assign hblank       = (col_q >= COL_HVIS);
  assign vblank       = (vcount_q >= ROW_VVIS) && (vcount_q <= ROW_VBL_LAST);
  assign vcount_match = (vcount_q == lyc_q);

  // Gating uses the current register values, so a same-cycle write cannot qualify its own event.
  assign start_row      = start_row_q & enable;
  assign new_frame      = start_row & (vcount_q == 8'd0);
  assign hbl_pulse      = hbl_ent_q & enable;
  assign vbl_pulse      = start_row & (vcount_q == ROW_VVIS);
  assign irq_vblank     = vbl_pulse & vblank_ie_q;
  assign irq_hblank     = hbl_pulse & hblank_ie_q;
  assign irq_vcount     = start_row & vcount_match & vcnt_ie_q;
  assign dma_hblank_req = hbl_pulse & (vcount_q < ROW_VVIS);
  assign dma_vblank_req = vbl_pulse;

  assign dispstat = {lyc_q, 2'b00, vcnt_ie_q, hblank_ie_q, vblank_ie_q,
                     vcount_match, hblank, vblank};

endmodule

// File: tb/tb_lcd_timing_controller.sv
// Directed bench for lcd_timing_controller on a reduced raster (4 slots, 20x12 dots/lines).
module tb_lcd_timing_controller;

  localparam int S     = 4;
  localparam int HT    = 20;
  localparam int HV    = 15;
  localparam int VT    = 12;
  localparam int VV    = 8;
  localparam int LINE  = S * HT;
  localparam int FRAME = LINE * VT;

  logic        clock = 1'b0;
  logic        rst_b = 1'b0;
  logic        enable = 1'b0;
  logic        dispstat_wr = 1'b0;
  logic [15:0] dispstat_wdata = 16'h0000;
  logic [15:0] dispstat;
  logic [7:0]  vcount;
  logic [8:0]  col;
  logic [1:0]  slot;
  logic        hblank, vblank, vcount_match, start_row, new_frame, frame;
  logic        irq_vblank, irq_hblank, irq_vcount, dma_hblank_req, dma_vblank_req;

  int checks = 0;
  int errors = 0;
  int pos = 0;
  int n_sr, n_nf, n_ivb, n_ihb, n_ivc, n_dh, n_dv, n_match;

  lcd_timing_controller #(
    .SLOTS(S), .H_TOTAL(HT), .H_VISIBLE(HV), .V_TOTAL(VT), .V_VISIBLE(VV)
  ) dut (
    .clock(clock), .rst_b(rst_b), .enable(enable),
    .dispstat_wr(dispstat_wr), .dispstat_wdata(dispstat_wdata),
    .dispstat(dispstat), .vcount(vcount), .col(col), .slot(slot),
    .hblank(hblank), .vblank(vblank), .vcount_match(vcount_match),
    .start_row(start_row), .new_frame(new_frame), .frame(frame),
    .irq_vblank(irq_vblank), .irq_hblank(irq_hblank), .irq_vcount(irq_vcount),
    .dma_hblank_req(dma_hblank_req), .dma_vblank_req(dma_vblank_req)
  );

  always #5 clock = ~clock;

  function automatic int e_row(input int p);
    return (p / LINE) % VT;
  endfunction

  task automatic tick();
    if (enable) pos++;
    @(posedge clock);
    #1;
  endtask

  task automatic clr();
    n_sr = 0; n_nf = 0; n_ivb = 0; n_ihb = 0; n_ivc = 0; n_dh = 0; n_dv = 0; n_match = 0;
  endtask

  task automatic acc();
    n_sr    += int'(start_row);
    n_nf    += int'(new_frame);
    n_ivb   += int'(irq_vblank);
    n_ihb   += int'(irq_hblank);
    n_ivc   += int'(irq_vcount);
    n_dh    += int'(dma_hblank_req);
    n_dv    += int'(dma_vblank_req);
    n_match += int'(vcount_match);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      acc();
    end
  endtask

  task automatic test_reset();
    rst_b = 1'b0;
    enable = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if (dispstat !== 16'h0004) begin
      errors++; $display("FAIL reset_dispstat: got %h expected 0004", dispstat);
    end
    checks++;
    if ({vcount, col, slot, frame} !== 20'd0) begin
      errors++; $display("FAIL reset_counters: got v=%0d c=%0d s=%0d f=%0d expected all 0", vcount, col, slot, frame);
    end
    @(negedge clock);
    rst_b = 1'b1;
    @(posedge clock);
    #1;
    enable = 1'b1;
    #1;
    checks++;
    if ({start_row, new_frame, irq_vblank, irq_hblank, irq_vcount, dma_hblank_req, dma_vblank_req} !== 7'd0) begin
      errors++; $display("FAIL reset_no_pulse: got pulses %b expected 0000000",
        {start_row, new_frame, irq_vblank, irq_hblank, irq_vcount, dma_hblank_req, dma_vblank_req});
    end
  endtask

  task automatic test_free_run();
    int first_sr, sr_row, first_nf, nf_frame, frame_before, hb59, hb60, hb80;
    logic exp_vb;
    first_sr = -1; sr_row = -1; first_nf = -1; nf_frame = -1;
    frame_before = -1; hb59 = -1; hb60 = -1; hb80 = -1;
    clr();
    for (int c = 1; c <= FRAME; c++) begin
      tick();
      acc();
      if (start_row && first_sr < 0) begin first_sr = pos; sr_row = int'(vcount); end
      if (new_frame && first_nf < 0) begin first_nf = pos; nf_frame = int'(frame); end
      if (pos == FRAME - 1) frame_before = int'(frame);
      if (pos == 59) hb59 = int'(hblank);
      if (pos == 60) hb60 = int'(hblank);
      if (pos == 80) hb80 = int'(hblank);
      if (pos % LINE == 0) begin
        exp_vb = (e_row(pos) >= VV) && (e_row(pos) <= VT - 2);
        checks++;
        if (vcount !== 8'(e_row(pos)) || vblank !== exp_vb) begin
          errors++; $display("FAIL line_vblank: got v=%0d vb=%b expected v=%0d vb=%b", vcount, vblank, e_row(pos), exp_vb);
        end
      end
    end
    checks++;
    if (first_sr != LINE || sr_row != 1) begin
      errors++; $display("FAIL first_start_row: got cycle %0d row %0d expected cycle %0d row 1", first_sr, sr_row, LINE);
    end
    checks++;
    if (first_nf != FRAME || nf_frame != 1 || frame_before != 0) begin
      errors++; $display("FAIL new_frame: got cycle %0d frame %0d->%0d expected cycle %0d frame 0->1", first_nf, frame_before, nf_frame, FRAME);
    end
    checks++;
    if (hb59 != 0 || hb60 != 1 || hb80 != 0) begin
      errors++; $display("FAIL hblank_edges: got %0d%0d%0d expected 010", hb59, hb60, hb80);
    end
    checks++;
    if (n_sr != VT || n_nf != 1) begin
      errors++; $display("FAIL strobe_counts: got sr=%0d nf=%0d expected sr=%0d nf=1", n_sr, n_nf, VT);
    end
    checks++;
    if (n_dh != VV || n_dv != 1 || (n_ivb + n_ihb + n_ivc) != 0) begin
      errors++; $display("FAIL free_run_dma: got dh=%0d dv=%0d irq=%0d expected dh=%0d dv=1 irq=0", n_dh, n_dv, n_ivb + n_ihb + n_ivc, VV);
    end
  endtask

  task automatic test_irq_gating();
    dispstat_wdata = 16'h0018;
    dispstat_wr = 1'b1;
    clr();
    tick();
    dispstat_wr = 1'b0;
    acc();
    checks++;
    if (dispstat !== 16'h001C) begin
      errors++; $display("FAIL ie_readback: got %h expected 001c", dispstat);
    end
    run(FRAME - 1);
    checks++;
    if (n_ivb != 1 || n_ihb != VT || n_ivc != 0) begin
      errors++; $display("FAIL irq_enabled: got vb=%0d hb=%0d vc=%0d expected vb=1 hb=%0d vc=0", n_ivb, n_ihb, n_ivc, VT);
    end
    dispstat_wdata = 16'h0000;
    dispstat_wr = 1'b1;
    clr();
    tick();
    dispstat_wr = 1'b0;
    acc();
    run(FRAME - 1);
    checks++;
    if ((n_ivb + n_ihb + n_ivc) != 0 || n_dh != VV || n_dv != 1) begin
      errors++; $display("FAIL irq_disabled: got irq=%0d dh=%0d dv=%0d expected irq=0 dh=%0d dv=1", n_ivb + n_ihb + n_ivc, n_dh, n_dv, VV);
    end
  endtask

  task automatic test_vcount_match();
    int irq_at, irq_row, bad;
    irq_at = -1; irq_row = -1; bad = 0;
    dispstat_wdata = 16'h0520;
    dispstat_wr = 1'b1;
    clr();
    for (int i = 0; i < FRAME; i++) begin
      tick();
      dispstat_wr = 1'b0;
      acc();
      if (irq_vcount) begin irq_at = pos; irq_row = int'(vcount); end
      if (vcount_match && vcount !== 8'd5) bad++;
    end
    checks++;
    if (n_ivc != 1 || irq_at != 3 * FRAME + 5 * LINE || irq_row != 5) begin
      errors++; $display("FAIL irq_vcount: got n=%0d at %0d row %0d expected n=1 at %0d row 5", n_ivc, irq_at, irq_row, 3 * FRAME + 5 * LINE);
    end
    checks++;
    if (n_match != LINE || bad != 0) begin
      errors++; $display("FAIL match_line: got %0d cycles (%0d off-line) expected %0d cycles", n_match, bad, LINE);
    end
    run(170);
    checks++;
    if (vcount_match !== 1'b0 || vcount !== 8'd2) begin
      errors++; $display("FAIL pre_write_match: got m=%b v=%0d expected m=0 v=2", vcount_match, vcount);
    end
    dispstat_wdata = 16'h0220;
    dispstat_wr = 1'b1;
    tick();
    dispstat_wr = 1'b0;
    checks++;
    if (vcount_match !== 1'b1 || irq_vcount !== 1'b0 || dispstat[15:8] !== 8'd2) begin
      errors++; $display("FAIL lyc_eq_current: got m=%b irq=%b lyc=%0d expected m=1 irq=0 lyc=2", vcount_match, irq_vcount, dispstat[15:8]);
    end
    clr();
    run(69);
    checks++;
    if (n_ivc != 0 || vcount_match !== 1'b0) begin
      errors++; $display("FAIL lyc_eq_no_irq: got irq=%0d m=%b expected irq=0 m=0", n_ivc, vcount_match);
    end
  endtask

  task automatic test_stall();
    int bad;
    bad = 0;
    dispstat_wdata = 16'h0010;
    dispstat_wr = 1'b1;
    tick();
    dispstat_wr = 1'b0;
    run(58);
    tick();
    enable = 1'b0;
    #1;
    checks++;
    if (irq_hblank !== 1'b0 || dma_hblank_req !== 1'b0 || col !== 9'd15 || slot !== 2'd0) begin
      errors++; $display("FAIL stall_entry: got irq=%b dma=%b c=%0d s=%0d expected irq=0 dma=0 c=15 s=0", irq_hblank, dma_hblank_req, col, slot);
    end
    clr();
    for (int i = 0; i < 50; i++) begin
      tick();
      acc();
      if (col !== 9'd15 || slot !== 2'd0 || vcount !== 8'd3) bad++;
    end
    checks++;
    if ((n_sr + n_ivb + n_ihb + n_ivc + n_dh + n_dv) != 0 || bad != 0) begin
      errors++; $display("FAIL stall_hold: got pulses=%0d moved=%0d expected 0 0", n_sr + n_ivb + n_ihb + n_ivc + n_dh + n_dv, bad);
    end
    enable = 1'b1;
    #1;
    checks++;
    if (irq_hblank !== 1'b1 || dma_hblank_req !== 1'b1) begin
      errors++; $display("FAIL stall_release: got irq=%b dma=%b expected 1 1", irq_hblank, dma_hblank_req);
    end
    tick();
    checks++;
    if (irq_hblank !== 1'b0 || slot !== 2'd1) begin
      errors++; $display("FAIL stall_once: got irq=%b s=%0d expected irq=0 s=1", irq_hblank, slot);
    end
  endtask

  task automatic test_simul_write();
    dispstat_wdata = 16'h0000;
    dispstat_wr = 1'b1;
    tick();
    dispstat_wr = 1'b0;
    run(77);
    tick();
    dispstat_wdata = 16'h0010;
    dispstat_wr = 1'b1;
    #1;
    checks++;
    if (irq_hblank !== 1'b0 || dma_hblank_req !== 1'b1) begin
      errors++; $display("FAIL simul_write: got irq=%b dma=%b expected irq=0 dma=1", irq_hblank, dma_hblank_req);
    end
    tick();
    dispstat_wr = 1'b0;
    checks++;
    if (dispstat[4] !== 1'b1) begin
      errors++; $display("FAIL simul_readback: got hblank_ie=%b expected 1", dispstat[4]);
    end
    clr();
    run(79);
    checks++;
    if (n_ihb != 1 || irq_hblank !== 1'b1 || col !== 9'd15) begin
      errors++; $display("FAIL next_line_irq: got n=%0d irq=%b c=%0d expected n=1 irq=1 c=15", n_ihb, irq_hblank, col);
    end
  endtask

  task automatic test_reset_mid();
    rst_b = 1'b0;
    #1;
    checks++;
    if (irq_hblank !== 1'b0 || dma_hblank_req !== 1'b0 || col !== 9'd0 || dispstat !== 16'h0004) begin
      errors++; $display("FAIL reset_mid: got irq=%b dma=%b c=%0d ds=%h expected 0 0 0 0004", irq_hblank, dma_hblank_req, col, dispstat);
    end
    pos = 0;
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_irq_gating();
    test_vcount_match();
    test_stall();
    test_simul_write();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
